// File: rtl/spart_pkg.sv
// Shared definitions for the SPART serial port: bus register map, reset divisor
// and the receive state machine encoding.
package spart_pkg;

  localparam logic [1:0]  ADDR_DATA   = 2'b00;
  localparam logic [1:0]  ADDR_STAT   = 2'b01;
  localparam logic [1:0]  ADDR_DBL    = 2'b10;
  localparam logic [1:0]  ADDR_DBH    = 2'b11;

  localparam logic [15:0] DEFAULT_DIV = 16'd324;

  // RX_WAIT holds off after a framing error until the line returns high
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_e;

endpackage

// File: rtl/spart_if.sv
// Processor-side control/status bundle of the SPART; the data bus itself stays
// a plain inout port on the unit.
interface spart_if;

  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);

endinterface

// File: rtl/spart_baud_gen.sv
// Baud tick generator: counts down from the divisor and emits a one-clock
// enable at zero, giving one enable every divisor+1 clocks.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter logic [15:0] RESET_DIV = DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] divisor,
  input  logic        reload,
  output logic        baud_en
);

  logic [15:0] cnt_q, cnt_d;

  // divisor is the next-state value so a bus write reloads with the new byte
  always_comb begin
    baud_en = (cnt_q == 16'd0);
    cnt_d   = cnt_q - 16'd1;
    if (reload || baud_en) begin
      cnt_d = divisor;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RESET_DIV;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spart_unit.sv
// SPART top: 8N1 serial port with bus-programmable divisor, 16x oversampled
// receiver and a single-byte transmit buffer.
module spart_unit #(
  parameter logic [15:0] DEFAULT_DIV = spart_pkg::DEFAULT_DIV
) (
  input  logic       clk,
  input  logic       rst,
  spart_if.slave     bus,
  inout  wire  [7:0] databus,
  output logic       txd,
  input  logic       rxd
);

  import spart_pkg::*;

  logic        wr_data, rd_data, wr_div, drive_en, tx_write;
  logic [7:0]  bus_in, bus_out;
  logic [15:0] div_q, div_d;
  logic        baud_en;

  logic        tbr_q, tbr_d;
  logic        txd_q, txd_d;
  logic [8:0]  tx_shift_q, tx_shift_d;
  logic [3:0]  tx_tick_q, tx_tick_d;
  logic [3:0]  tx_bit_q, tx_bit_d;

  logic        rx_meta_q, rx_sync_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [3:0]  rx_tick_q, rx_tick_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_buf_q, rx_buf_d;
  logic        rda_q, rda_d;
  logic        rx_load;

  assign bus_in   = databus;
  assign wr_data  = bus.iocs & ~bus.iorw & (bus.ioaddr == ADDR_DATA);
  assign rd_data  = bus.iocs &  bus.iorw & (bus.ioaddr == ADDR_DATA);
  assign wr_div   = bus.iocs & ~bus.iorw & bus.ioaddr[1];
  assign drive_en = bus.iocs &  bus.iorw & ~bus.ioaddr[1];
  assign tx_write = wr_data & tbr_q;

  assign bus_out  = (bus.ioaddr == ADDR_STAT) ? {6'b0, tbr_q, rda_q} : rx_buf_q;
  assign databus  = drive_en ? bus_out : 8'hzz;

  assign txd      = txd_q;
  assign bus.rda  = rda_q;
  assign bus.tbr  = tbr_q;

  always_comb begin
    div_d = div_q;
    if (wr_div && (bus.ioaddr == ADDR_DBL)) div_d[7:0]  = bus_in;
    if (wr_div && (bus.ioaddr == ADDR_DBH)) div_d[15:8] = bus_in;
  end

  spart_baud_gen #(
    .RESET_DIV (DEFAULT_DIV)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .divisor (div_d),
    .reload  (wr_div),
    .baud_en (baud_en)
  );

  // Transmitter: tx_bit 0 is the start bit, 1..8 data, 9 the stop bit
  always_comb begin
    tbr_d      = tbr_q;
    txd_d      = txd_q;
    tx_shift_d = tx_shift_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    if (!tbr_q) begin
      if (baud_en) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == 4'd15) begin
          if (tx_bit_q == 4'd9) begin
            tbr_d = 1'b1;
            txd_d = 1'b1;
          end else begin
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end
      end
    end else if (tx_write) begin
      tbr_d      = 1'b0;
      txd_d      = 1'b0;
      tx_shift_d = {1'b1, bus_in};
      tx_tick_d  = 4'd0;
      tx_bit_d   = 4'd0;
    end
  end

  // Receiver: sample points are mid-bit, 8 ticks into the start bit then every 16
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_buf_d   = rx_buf_q;
    rx_load    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_tick_d  = 4'd0;
        end
      end
      RX_START: begin
        if (baud_en) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd7) begin
            rx_tick_d  = 4'd0;
            rx_bit_d   = 3'd0;
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (baud_en) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (baud_en) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            if (rx_sync_q) begin
              rx_load    = 1'b1;
              rx_buf_d   = rx_shift_q;
              rx_state_d = RX_IDLE;
            end else begin
              rx_state_d = RX_WAIT;
            end
          end
        end
      end
      RX_WAIT: begin
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase

    rda_d = rda_q;
    if (rd_data) rda_d = 1'b0;
    if (rx_load) rda_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= DEFAULT_DIV;
      tbr_q      <= 1'b1;
      txd_q      <= 1'b1;
      tx_shift_q <= 9'h1FF;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 4'd0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_buf_q   <= 8'h00;
      rda_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      tbr_q      <= tbr_d;
      txd_q      <= txd_d;
      tx_shift_q <= tx_shift_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      rx_meta_q  <= rxd;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_buf_q   <= rx_buf_d;
      rda_q      <= rda_d;
    end
  end

endmodule

// File: tb/tb_spart_unit.sv
// Self-checking bench for spart_unit: bus access, TX framing/timing, table of
// RX frames checked through a byte scoreboard, and multi-cycle corner cases.
module tb_spart_unit;

  import spart_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       expect_rda;
  } rx_vec_t;

  localparam int NV = 5;

  logic       clk = 1'b0;
  logic       rst;
  wire  [7:0] databus;
  logic       txd;
  logic       rxd;
  logic       tb_drv;
  logic [7:0] tb_data;
  logic       loop_en;
  logic       rx_line;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  rx_vec_t    vecs[NV];

  logic [7:0]   rd;
  logic         seen;
  logic [7:0]   cap;
  logic [9:0]   frame;
  logic [9:0]   tx_got;
  logic [799:0] tx_trace;
  int           tbr_low;
  int           t_fall;
  int           t_rise;

  spart_if bus ();

  spart_unit dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .databus (databus),
    .txd     (txd),
    .rxd     (rxd)
  );

  pullup (databus);
  assign databus = tb_drv ? tb_data : 8'hzz;
  assign rxd     = loop_en ? txd : rx_line;

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    n_checks++;
    if (actual < lo || actual > hi) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0d required %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic rw, input logic [1:0] addr,
                               input logic drv, input logic [7:0] data);
    bus.iocs   = cs;
    bus.iorw   = rw;
    bus.ioaddr = addr;
    tb_drv     = drv;
    tb_data    = data;
  endtask

  task automatic busIdle();
    applyStimulus(1'b0, 1'b1, ADDR_DATA, 1'b0, 8'h00);
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, addr, 1'b1, data);
    @(posedge clk);
    #1 busIdle();
  endtask

  task automatic busRead(input logic [1:0] addr, output logic [7:0] data);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, addr, 1'b0, 8'h00);
    #2 data = databus;
    @(posedge clk);
    #1 busIdle();
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, data, 1'b0};
    @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      rx_line = f[b];
      repeat (64) @(negedge clk);
    end
    rx_line = 1'b1;
  endtask

  task automatic waitFor(input int max_clks, input logic want_rda, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < max_clks && !hit; i++) begin
      @(negedge clk);
      hit = want_rda ? bus.rda : bus.tbr;
    end
  endtask

  initial begin
    rst     = 1'b1;
    loop_en = 1'b0;
    rx_line = 1'b1;
    busIdle();

    vecs[0] = '{data: 8'h3C, stop: 1'b1, expect_rda: 1'b1};
    vecs[1] = '{data: 8'h00, stop: 1'b1, expect_rda: 1'b1};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, expect_rda: 1'b1};
    vecs[3] = '{data: 8'hA5, stop: 1'b0, expect_rda: 1'b0};
    vecs[4] = '{data: 8'h96, stop: 1'b1, expect_rda: 1'b1};

    repeat (3) @(negedge clk);
    checkOutput("reset_txd", 16'(txd), 16'h1);
    checkOutput("reset_tbr", 16'(bus.tbr), 16'h1);
    checkOutput("reset_rda", 16'(bus.rda), 16'h0);
    checkOutput("reset_bus_z", 16'(databus), 16'h00FF);
    rst = 1'b0;

    busRead(ADDR_STAT, rd);
    checkOutput("status_after_reset", 16'(rd), 16'h0002);
    busRead(ADDR_DATA, rd);
    checkOutput("rxbuf_after_reset", 16'(rd), 16'h0000);

    @(negedge clk);
    applyStimulus(1'b1, 1'b1, ADDR_DBL, 1'b0, 8'h00);
    #2 checkOutput("read_div_not_driven", 16'(databus), 16'h00FF);
    @(posedge clk);
    #1 busIdle();

    // Loopback at the reset divisor
    loop_en = 1'b1;
    busWrite(ADDR_DATA, 8'h81);
    exp_q.push_back(8'h81);
    busRead(ADDR_STAT, rd);
    checkOutput("status_tx_busy", 16'(rd), 16'h0000);
    waitFor(60000, 1'b1, seen);
    checkOutput("loop_rda", 16'(seen), 16'h1);
    busRead(ADDR_DATA, rd);
    checkOutput("loop_data", 16'(rd), 16'(exp_q.pop_front()));
    @(negedge clk);
    checkOutput("loop_rda_clear", 16'(bus.rda), 16'h0);
    waitFor(10000, 1'b0, seen);
    checkOutput("loop_tbr_back", 16'(seen), 16'h1);
    loop_en = 1'b0;

    busWrite(ADDR_DBL, 8'h03);
    busWrite(ADDR_DBH, 8'h00);

    // TX of 8'hA5 at divisor 3, with an ignored write mid-frame
    busWrite(ADDR_DATA, 8'hA5);
    tbr_low = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      tx_trace[i] = txd;
      if (!bus.tbr) tbr_low++;
      if (i == 200) applyStimulus(1'b1, 1'b0, ADDR_DATA, 1'b1, 8'h00);
      else if (i == 201) busIdle();
    end
    for (int k = 0; k < 10; k++) tx_got[k] = tx_trace[31 + 64 * k];
    checkOutput("tx_start_immediate", 16'(tx_trace[0]), 16'h0);
    checkOutput("tx_frame_bits", 16'(tx_got), 16'({1'b1, 8'hA5, 1'b0}));
    checkRange("tx_tbr_low_clks", tbr_low, 637, 640);
    t_fall = -1;
    t_rise = -1;
    for (int i = 1; i < 800; i++) begin
      if (t_fall < 0 && tx_trace[i-1] && !tx_trace[i]) t_fall = i;
      else if (t_fall >= 0 && t_rise < 0 && tx_trace[i]) t_rise = i;
    end
    checkRange("tx_bit_clks", t_rise - t_fall, 64, 64);
    checkOutput("tx_idle_txd", 16'(txd), 16'h1);
    checkOutput("tx_idle_tbr", 16'(bus.tbr), 16'h1);

    // Table of RX frames through the scoreboard
    for (int v = 0; v < NV; v++) begin
      if (vecs[v].expect_rda) exp_q.push_back(vecs[v].data);
      sendFrame(vecs[v].data, vecs[v].stop);
      repeat (40) @(negedge clk);
      checkOutput($sformatf("rx_vec%0d_rda", v), 16'(bus.rda), 16'(vecs[v].expect_rda));
      if (bus.rda) begin
        busRead(ADDR_DATA, rd);
        if (exp_q.size() == 0) checkOutput($sformatf("rx_vec%0d_unexpected", v), 16'(rd), 16'hFFFF);
        else checkOutput($sformatf("rx_vec%0d_data", v), 16'(rd), 16'(exp_q.pop_front()));
        @(negedge clk);
        checkOutput($sformatf("rx_vec%0d_rda_clear", v), 16'(bus.rda), 16'h0);
      end
    end

    // False start glitch followed by a real frame
    @(negedge clk);
    rx_line = 1'b0;
    repeat (20) @(negedge clk);
    rx_line = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("false_start_rda", 16'(bus.rda), 16'h0);
    exp_q.push_back(8'h55);
    sendFrame(8'h55, 1'b1);
    repeat (40) @(negedge clk);
    checkOutput("after_glitch_rda", 16'(bus.rda), 16'h1);
    busRead(ADDR_DATA, rd);
    checkOutput("after_glitch_data", 16'(rd), 16'(exp_q.pop_front()));

    // Overrun: second byte replaces the first
    sendFrame(8'h11, 1'b1);
    repeat (20) @(negedge clk);
    sendFrame(8'h22, 1'b1);
    repeat (40) @(negedge clk);
    checkOutput("overrun_rda", 16'(bus.rda), 16'h1);
    busRead(ADDR_DATA, rd);
    checkOutput("overrun_data", 16'(rd), 16'h0022);

    // Continuous data reads across the stop bit: the load must still raise rda
    frame = {1'b1, 8'h5A, 1'b0};
    @(negedge clk);
    for (int b = 0; b < 9; b++) begin
      rx_line = frame[b];
      repeat (64) @(negedge clk);
    end
    rx_line = 1'b1;
    applyStimulus(1'b1, 1'b1, ADDR_DATA, 1'b0, 8'h00);
    seen = 1'b0;
    cap  = 8'h00;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.rda && !seen) begin
        seen = 1'b1;
        cap  = databus;
      end
    end
    busIdle();
    checkOutput("load_vs_read_rda", 16'(seen), 16'h1);
    checkOutput("load_vs_read_data", 16'(cap), 16'h005A);
    @(negedge clk);
    checkOutput("load_vs_read_cleared", 16'(bus.rda), 16'h0);

    // Reset in the middle of a transmit frame
    busWrite(ADDR_DATA, 8'h00);
    repeat (100) @(negedge clk);
    checkOutput("midframe_txd_low", 16'(txd), 16'h0);
    rst = 1'b1;
    #1;
    checkOutput("midframe_reset_txd", 16'(txd), 16'h1);
    checkOutput("midframe_reset_tbr", 16'(bus.tbr), 16'h1);
    checkOutput("midframe_reset_rda", 16'(bus.rda), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    busRead(ADDR_STAT, rd);
    checkOutput("status_after_midframe_reset", 16'(rd), 16'h0002);

    checkOutput("scoreboard_empty", 16'(exp_q.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
